// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master round-robin arbiter for the single-port data RAM
//
// Shares one 1-cycle (RD_LAT) synchronous RAM between master 0 (CPU load/store)
// and master 1 (debug/loader). At most one access is granted per cycle. The
// current owner keeps the RAM for up to MAX_BURST consecutive grants while the
// other master waits, then ownership hands over with no idle cycle in between.
// Read data is steered back to the issuing master through a tag pipeline.
//
// Ports (x = 0, 1):
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   mx_req/we/addr    request, write flag, word address (held until granted)
//   mx_wdata/wmask    write data and byte enables
//   mx_gnt            request accepted this cycle (combinational)
//   mx_rvalid/rdata   read return pulse and data (data is 0 when not valid)
//   ram_en/we/addr    RAM strobe, write flag, address
//   ram_wdata/wmask   RAM write data and byte enables
//   ram_rdata         RAM read data, valid RD_LAT cycles after a read strobe
module ram_arbiter #(
    parameter int DW        = 64,
    parameter int AW        = 12,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    output logic [DW/8-1:0] ram_wmask,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            prio_q, prio_d;

    // Read tag pipeline: stage i holds {valid, master id} of a read issued i+1 cycles ago.
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;

    logic gnt_any;   // some master granted this cycle
    logic gnt_id;    // which master (valid when gnt_any)
    logic own;       // current owner id while in OWN0/OWN1
    logic req_own;
    logic req_oth;

    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] sel_wmask;

    logic            ret_vld;
    logic            ret_id;

    // Arbitration and next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        own     = (state_q == OWN1);
        req_own = own ? m1_req : m0_req;
        req_oth = own ? m0_req : m1_req;

        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    gnt_any = 1'b1;
                    gnt_id  = prio_q;
                end else if (m0_req) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end else if (m1_req) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
                if (gnt_any) begin
                    state_d = gnt_id ? OWN1 : OWN0;
                    cnt_d   = ONE_CNT;
                end
            end
            OWN0, OWN1: begin
                // The owner may keep going while under its burst budget, or
                // indefinitely when nobody else wants the RAM.
                if (req_own && ((cnt_q < MAX_CNT) || !req_oth)) begin
                    gnt_any = 1'b1;
                    gnt_id  = own;
                    cnt_d   = (cnt_q < MAX_CNT) ? cnt_q + ONE_CNT : MAX_CNT;
                end else if (req_oth) begin
                    gnt_any = 1'b1;
                    gnt_id  = ~own;
                    state_d = own ? OWN0 : OWN1;
                    cnt_d   = ONE_CNT;
                    prio_d  = own;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    prio_d  = ~own;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Reset is asynchronous; keep the RAM quiet for the whole assertion.
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    // Granted master's request fields
    always_comb begin
        sel_we    = gnt_id ? m1_we    : m0_we;
        sel_addr  = gnt_id ? m1_addr  : m0_addr;
        sel_wdata = gnt_id ? m1_wdata : m0_wdata;
        sel_wmask = gnt_id ? m1_wmask : m0_wmask;
    end

    // Tag pipeline shift; a new tag enters only for granted reads
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = gnt_any & ~sel_we;
        tag_id_d[0]  = gnt_id;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign m0_gnt    = gnt_any & ~gnt_id;
    assign m1_gnt    = gnt_any &  gnt_id;

    assign ram_en    = gnt_any;
    assign ram_we    = gnt_any & sel_we;
    assign ram_addr  = gnt_any ? sel_addr  : '0;
    assign ram_wdata = gnt_any ? sel_wdata : '0;
    assign ram_wmask = gnt_any ? sel_wmask : '0;

    assign ret_vld   = tag_vld_q[RD_LAT-1];
    assign ret_id    = tag_id_q[RD_LAT-1];

    assign m0_rvalid = ret_vld & ~ret_id;
    assign m1_rvalid = ret_vld &  ret_id;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter (default and RD_LAT=2/MAX_BURST=1 instances)
module tb_ram_arbiter;

    logic clk;
    int   checks;
    int   failures;

    // Instance A: RD_LAT=1, MAX_BURST=4
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [11:0] m0_addr, m1_addr;
    logic [63:0] m0_wdata, m1_wdata;
    logic [7:0]  m0_wmask, m1_wmask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [63:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [63:0] ram_wdata, ram_rdata;
    logic [7:0]  ram_wmask;

    // Instance B: RD_LAT=2, MAX_BURST=1
    logic        rst_b;
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [11:0] b_m0_addr, b_m1_addr;
    logic [63:0] b_m0_wdata, b_m1_wdata;
    logic [7:0]  b_m0_wmask, b_m1_wmask;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [63:0] b_m0_rdata, b_m1_rdata;
    logic        b_ram_en, b_ram_we;
    logic [11:0] b_ram_addr;
    logic [63:0] b_ram_wdata, b_ram_rdata;
    logic [7:0]  b_ram_wmask;

    ram_arbiter #(.DW(64), .AW(12), .RD_LAT(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.DW(64), .AW(12), .RD_LAT(2), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst_b),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_wmask(b_m0_wmask), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_wmask(b_m1_wmask), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_wmask(b_ram_wmask), .ram_rdata(b_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: 4096 x 64, byte-masked writes, synchronous read
    logic [63:0] mem_a [4096];
    logic [63:0] mem_b [4096];
    logic [63:0] rd_a, rd_b1, rd_b2;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int i = 0; i < 8; i++)
                    if (ram_wmask[i]) mem_a[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
            end else begin
                rd_a <= mem_a[ram_addr];
            end
        end
    end
    assign ram_rdata = rd_a;

    always @(posedge clk) begin
        rd_b2 <= rd_b1;
        if (b_ram_en) begin
            if (b_ram_we) begin
                for (int i = 0; i < 8; i++)
                    if (b_ram_wmask[i]) mem_b[b_ram_addr][i*8 +: 8] <= b_ram_wdata[i*8 +: 8];
            end else begin
                rd_b1 <= mem_b[b_ram_addr];
            end
        end
    end
    assign b_ram_rdata = rd_b2;

    task automatic set_m0(input logic r, input logic w, input logic [11:0] a,
                          input logic [63:0] d, input logic [7:0] m);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_wmask = m;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [11:0] a,
                          input logic [63:0] d, input logic [7:0] m);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_wmask = m;
    endtask

    task automatic set_b0(input logic r, input logic w, input logic [11:0] a);
        b_m0_req = r; b_m0_we = w; b_m0_addr = a; b_m0_wdata = '0; b_m0_wmask = '0;
    endtask

    task automatic set_b1(input logic r, input logic w, input logic [11:0] a);
        b_m1_req = r; b_m1_we = w; b_m1_addr = a; b_m1_wdata = '0; b_m1_wmask = '0;
    endtask

    task automatic do_reset_a;
        @(negedge clk);
        set_m0(0, 0, '0, '0, '0);
        set_m1(0, 0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset_b;
        @(negedge clk);
        set_b0(0, 0, '0);
        set_b1(0, 0, '0);
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        set_m0(1, 1, 12'h0AA, 64'hDEAD, 8'hFF);
        set_m1(1, 0, 12'h055, '0, '0);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({m0_gnt, m1_gnt} !== 2'b00) begin
                failures++; $display("FAIL reset_gnt got=%b exp=00", {m0_gnt, m1_gnt});
            end
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_wdata, ram_wmask} !== '0) begin
                failures++; $display("FAIL reset_ram got en=%b we=%b addr=%h exp all 0", ram_en, ram_we, ram_addr);
            end
            checks++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
                failures++; $display("FAIL reset_resp got rv=%b%b exp 00 and rdata 0", m0_rvalid, m1_rvalid);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++; $display("FAIL reset_release_prio got=%b exp=10", {m0_gnt, m1_gnt});
        end
        set_m0(0, 0, '0, '0, '0);
        set_m1(0, 0, '0, '0, '0);
    endtask

    task automatic test_single_master;
        do_reset_a;
        @(negedge clk);
        set_m1(1, 1, 12'h010, 64'h1122334455667788, 8'hFF);
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            failures++; $display("FAIL single_wr_gnt got=%b exp=01", {m0_gnt, m1_gnt});
        end
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, ram_wmask} !== {1'b1, 1'b1, 12'h010, 64'h1122334455667788, 8'hFF}) begin
            failures++; $display("FAIL single_wr_ram got en=%b we=%b addr=%h wdata=%h mask=%h exp 1 1 010 1122334455667788 ff",
                                 ram_en, ram_we, ram_addr, ram_wdata, ram_wmask);
        end
        @(negedge clk);
        set_m1(1, 0, 12'h010, '0, '0);
        #1;
        checks++;
        if ({m1_gnt, ram_en, ram_we} !== 3'b110) begin
            failures++; $display("FAIL single_rd_gnt got gnt/en/we=%b exp=110", {m1_gnt, ram_en, ram_we});
        end
        @(negedge clk);
        set_m1(0, 0, '0, '0, '0);
        #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 64'h1122334455667788) begin
            failures++; $display("FAIL single_rd_data got rv=%b data=%h exp rv=1 data=1122334455667788", m1_rvalid, m1_rdata);
        end
        checks++;
        if ({m0_gnt, m0_rvalid, m0_rdata} !== '0) begin
            failures++; $display("FAIL single_m0_quiet got gnt=%b rv=%b data=%h exp all 0", m0_gnt, m0_rvalid, m0_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m1_rvalid !== 1'b0) begin
            failures++; $display("FAIL single_rv_pulse got=%b exp=0", m1_rvalid);
        end
    endtask

    task automatic test_contention;
        logic e1;
        do_reset_a;
        @(negedge clk);
        set_m0(1, 0, 12'h100, '0, '0);
        set_m1(1, 0, 12'h200, '0, '0);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            e1 = ((i / 4) % 2) == 1;
            checks++;
            if ({m0_gnt, m1_gnt, ram_en} !== {~e1, e1, 1'b1}) begin
                failures++; $display("FAIL contention_c%0d got gnt0/gnt1/en=%b exp=%b", i, {m0_gnt, m1_gnt, ram_en}, {~e1, e1, 1'b1});
            end
        end
        set_m0(0, 0, '0, '0, '0);
        set_m1(0, 0, '0, '0, '0);
    endtask

    task automatic test_partial_write;
        do_reset_a;
        @(negedge clk);
        set_m0(1, 1, 12'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        #1;
        checks++;
        if (m0_gnt !== 1'b1) begin
            failures++; $display("FAIL partial_wr1_gnt got=%b exp=1", m0_gnt);
        end
        @(negedge clk);
        set_m0(1, 1, 12'h020, 64'h0, 8'h0F);
        #1;
        checks++;
        if (m0_gnt !== 1'b1 || ram_wmask !== 8'h0F) begin
            failures++; $display("FAIL partial_wr2 got gnt=%b mask=%h exp gnt=1 mask=0f", m0_gnt, ram_wmask);
        end
        @(negedge clk);
        set_m0(1, 0, 12'h020, '0, '0);
        @(negedge clk);
        set_m0(0, 0, '0, '0, '0);
        #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 64'hFFFFFFFF00000000) begin
            failures++; $display("FAIL partial_rd got rv=%b data=%h exp rv=1 data=ffffffff00000000", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_pipelined_reads;
        logic [63:0] da, db;
        logic        prev1;
        da = 64'hA0A0_A0A0_0000_0001;
        db = 64'hB0B0_B0B0_0000_0002;
        do_reset_a;
        @(negedge clk);
        set_m0(1, 1, 12'h001, da, 8'hFF);
        @(negedge clk);
        set_m0(0, 0, '0, '0, '0);
        set_m1(1, 1, 12'h002, db, 8'hFF);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) begin
                set_m0(0, 0, '0, '0, '0);
                set_m1(0, 0, '0, '0, '0);
            end else if (k % 2 == 0) begin
                set_m0(1, 0, 12'h001, '0, '0);
                set_m1(0, 0, '0, '0, '0);
            end else begin
                set_m0(0, 0, '0, '0, '0);
                set_m1(1, 0, 12'h002, '0, '0);
            end
            #1;
            if (k < 6) begin
                checks++;
                if ({m0_gnt, m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL pipe_gnt_k%0d got=%b", k, {m0_gnt, m1_gnt});
                end
            end
            if (k == 0) begin
                checks++;
                if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                    failures++; $display("FAIL pipe_no_wr_resp got=%b exp=00", {m0_rvalid, m1_rvalid});
                end
            end else begin
                prev1 = ((k - 1) % 2) == 1;
                checks++;
                if ({m0_rvalid, m1_rvalid} !== {~prev1, prev1}) begin
                    failures++; $display("FAIL pipe_rv_k%0d got=%b exp=%b", k, {m0_rvalid, m1_rvalid}, {~prev1, prev1});
                end
                checks++;
                if (m0_rdata !== (prev1 ? 64'h0 : da) || m1_rdata !== (prev1 ? db : 64'h0)) begin
                    failures++; $display("FAIL pipe_data_k%0d got m0=%h m1=%h", k, m0_rdata, m1_rdata);
                end
            end
        end
    endtask

    task automatic test_burst1_alternation;
        logic e1;
        do_reset_b;
        @(negedge clk);
        set_b0(1, 0, 12'h030);
        set_b1(1, 0, 12'h040);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            e1 = (i % 2) == 1;
            checks++;
            if ({b_m0_gnt, b_m1_gnt, b_ram_en} !== {~e1, e1, 1'b1}) begin
                failures++; $display("FAIL burst1_c%0d got gnt0/gnt1/en=%b exp=%b", i, {b_m0_gnt, b_m1_gnt, b_ram_en}, {~e1, e1, 1'b1});
            end
        end
        set_b0(0, 0, '0);
        set_b1(0, 0, '0);
    endtask

    task automatic test_reset_inflight;
        do_reset_b;
        @(negedge clk);
        set_b0(1, 0, 12'h005);
        #1;
        checks++;
        if (b_m0_gnt !== 1'b1) begin
            failures++; $display("FAIL inflight_gnt got=%b exp=1", b_m0_gnt);
        end
        @(negedge clk);
        set_b0(0, 0, '0);
        #2;
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({b_m0_rvalid, b_m1_rvalid} !== 2'b00) begin
                failures++; $display("FAIL inflight_rv_c%0d got=%b exp=00", c, {b_m0_rvalid, b_m1_rvalid});
            end
            @(negedge clk);
        end
        // Back in IDLE with prio 0: a tie must go to master 0.
        set_b0(1, 0, 12'h006);
        set_b1(1, 0, 12'h007);
        #1;
        checks++;
        if ({b_m0_gnt, b_m1_gnt} !== 2'b10) begin
            failures++; $display("FAIL inflight_idle_prio got=%b exp=10", {b_m0_gnt, b_m1_gnt});
        end
        @(negedge clk);
        set_b0(0, 0, '0);
        set_b1(0, 0, '0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rst_b    = 1'b1;
        set_m0(0, 0, '0, '0, '0);
        set_m1(0, 0, '0, '0, '0);
        set_b0(0, 0, '0);
        set_b1(0, 0, '0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;

        test_reset;
        test_single_master;
        test_contention;
        test_partial_write;
        test_pipelined_reads;
        test_burst1_alternation;
        test_reset_inflight;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
